// File: rtl/pps_trig_receiver_if.sv
// Signal bundle between the PPS trigger generator side and the trigger receiver.
// The master drives the raw SYNC/trigger lines and observes the receiver status.
interface pps_trig_receiver_if;
  logic        i_sync;
  logic        i_trig;
  logic        o_trig_stb;
  logic [31:0] o_pulse_idx;
  logic [31:0] o_period;
  logic [31:0] o_pulse_cnt_last;
  logic        o_err_period;
  logic        o_err_count;
  logic        o_err_timeout;
  logic        o_locked;
  logic [1:0]  o_state;

  modport master (
    output i_sync, i_trig,
    input  o_trig_stb, o_pulse_idx, o_period, o_pulse_cnt_last,
           o_err_period, o_err_count, o_err_timeout, o_locked, o_state
  );

  modport slave (
    input  i_sync, i_trig,
    output o_trig_stb, o_pulse_idx, o_period, o_pulse_cnt_last,
           o_err_period, o_err_count, o_err_timeout, o_locked, o_state
  );
endinterface

// File: rtl/pps_trig_receiver.sv
// Receive end of the PPS-synchronised trigger link. Synchronises SYNC and the
// trigger train, checks pulse count, spacing and timeout per PPS interval, and
// emits a one-cycle strobe per accepted trigger.
module pps_trig_receiver #(
  parameter int unsigned EXP_PULSES = 100,
  parameter int unsigned NOM_PERIOD = 1000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned TIMEOUT    = 2000000
) (
  input  logic i_clk,
  input  logic i_rst,
  pps_trig_receiver_if.slave bus
);

  localparam logic [1:0] WAIT_SYNC = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] TIMED_OUT = 2'd2;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Input conditioning: 2-FF synchroniser, delay register, registered edge.
  logic sync_s1_q, sync_s2_q, sync_dly_q, sync_edge_q;
  logic sync_s1_d, sync_s2_d, sync_dly_d, sync_edge_d;
  logic trig_s1_q, trig_s2_q, trig_dly_q, trig_edge_q;
  logic trig_s1_d, trig_s2_d, trig_dly_d, trig_edge_d;

  // Interval bookkeeping.
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_last_q, cnt_last_d;
  logic        err_period_q, err_period_d;
  logic        err_count_q, err_count_d;
  logic        err_timeout_q, err_timeout_d;
  logic        locked_q, locked_d;
  logic        stb_q, stb_d;

  logic [31:0]        cnt_inc;
  logic [31:0]        idx_inc;
  logic signed [32:0] diff;
  logic signed [32:0] diff_abs;
  logic               out_of_tol;

  // Synchroniser chain and rising-edge detection for SYNC and trigger.
  always_comb begin
    sync_s1_d   = bus.i_sync;
    sync_s2_d   = sync_s1_q;
    sync_dly_d  = sync_s2_q;
    sync_edge_d = sync_s2_q & ~sync_dly_q;
    trig_s1_d   = bus.i_trig;
    trig_s2_d   = trig_s1_q;
    trig_dly_d  = trig_s2_q;
    trig_edge_d = trig_s2_q & ~trig_dly_q;
  end

  // Saturating increments and the spacing tolerance test.
  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 32'd1;
    idx_inc    = (idx_q == CNT_MAX) ? idx_q : idx_q + 32'd1;
    diff       = $signed({1'b0, cnt_inc}) - $signed({1'b0, NOM_PERIOD});
    diff_abs   = diff[32] ? -diff : diff;
    out_of_tol = diff_abs > $signed({1'b0, TOL});
  end

  // Interval FSM: measures spacing, counts pulses, closes intervals on SYNC.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    period_d      = period_q;
    cnt_last_d    = cnt_last_q;
    err_period_d  = err_period_q;
    err_count_d   = err_count_q;
    err_timeout_d = err_timeout_q;
    locked_d      = locked_q;
    stb_d         = 1'b0;

    case (state_q)
      WAIT_SYNC: begin
        if (sync_edge_q) begin
          idx_d        = '0;
          cnt_d        = '0;
          err_period_d = 1'b0;
          state_d      = RUN;
        end
      end

      RUN, TIMED_OUT: begin
        cnt_d = cnt_inc;
        if (sync_edge_q) begin
          // Close the old interval before anything from the new one counts.
          cnt_last_d    = idx_q;
          err_count_d   = (idx_q != EXP_PULSES);
          locked_d      = (idx_q == EXP_PULSES) && !err_period_q && !err_timeout_q;
          idx_d         = '0;
          cnt_d         = '0;
          err_period_d  = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = RUN;
          // A coincident trigger is pulse 1 of the new interval; its spacing
          // from SYNC is zero, so o_period keeps its previous value.
          if (trig_edge_q) begin
            stb_d = 1'b1;
            idx_d = 32'd1;
          end
        end else if (trig_edge_q) begin
          stb_d    = 1'b1;
          idx_d    = idx_inc;
          period_d = cnt_inc;
          cnt_d    = '0;
          // First pulse is measured from SYNC and is not held to the tolerance.
          if (state_q == RUN && idx_q != 32'd0 && out_of_tol) begin
            err_period_d = 1'b1;
          end
        end else if (state_q == RUN && cnt_q >= TIMEOUT - 32'd1 &&
                     idx_q != EXP_PULSES) begin
          err_timeout_d = 1'b1;
          locked_d      = 1'b0;
          state_d       = TIMED_OUT;
        end
      end

      default: state_d = WAIT_SYNC;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      sync_s1_q     <= 1'b0;
      sync_s2_q     <= 1'b0;
      sync_dly_q    <= 1'b0;
      sync_edge_q   <= 1'b0;
      trig_s1_q     <= 1'b0;
      trig_s2_q     <= 1'b0;
      trig_dly_q    <= 1'b0;
      trig_edge_q   <= 1'b0;
      state_q       <= WAIT_SYNC;
      cnt_q         <= '0;
      idx_q         <= '0;
      period_q      <= '0;
      cnt_last_q    <= '0;
      err_period_q  <= 1'b0;
      err_count_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      locked_q      <= 1'b0;
      stb_q         <= 1'b0;
    end else begin
      sync_s1_q     <= sync_s1_d;
      sync_s2_q     <= sync_s2_d;
      sync_dly_q    <= sync_dly_d;
      sync_edge_q   <= sync_edge_d;
      trig_s1_q     <= trig_s1_d;
      trig_s2_q     <= trig_s2_d;
      trig_dly_q    <= trig_dly_d;
      trig_edge_q   <= trig_edge_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      period_q      <= period_d;
      cnt_last_q    <= cnt_last_d;
      err_period_q  <= err_period_d;
      err_count_q   <= err_count_d;
      err_timeout_q <= err_timeout_d;
      locked_q      <= locked_d;
      stb_q         <= stb_d;
    end
  end

  assign bus.o_trig_stb       = stb_q;
  assign bus.o_pulse_idx      = idx_q;
  assign bus.o_period         = period_q;
  assign bus.o_pulse_cnt_last = cnt_last_q;
  assign bus.o_err_period     = err_period_q;
  assign bus.o_err_count      = err_count_q;
  assign bus.o_err_timeout    = err_timeout_q;
  assign bus.o_locked         = locked_q;
  assign bus.o_state          = state_q;

endmodule
